// File: rtl/reloj_hhmmss_pkg.sv
// rtl/reloj_hhmmss_pkg.sv - shared constants, scan states and 7-segment helper for the clock
// Purpose: BCD limits, active-low 7-segment patterns {g,f,e,d,c,b,a}, blank pattern,
//          display scan state type and the digit-to-segment encoder.
// Ports:   none (package).
package reloj_hhmmss_pkg;

   localparam logic [3:0] BCD_UNITS_MAX = 4'd9;   // last units digit of any field
   localparam logic [3:0] BCD_TENS_MAX  = 4'd5;   // last tens digit of minutes/seconds
   localparam logic [3:0] HR_TENS_MAX   = 4'd2;   // hours tens at 2x ...
   localparam logic [3:0] HR_UNITS_MAX  = 4'd3;   // ... stop at 23

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [0:9][6:0] SEG_TABLE = {
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

   typedef enum logic [1:0] {
      SCAN_MIN_U = 2'd0,
      SCAN_MIN_T = 2'd1,
      SCAN_HR_U  = 2'd2,
      SCAN_HR_T  = 2'd3
   } scan_e;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      if (d > BCD_UNITS_MAX) begin
         return SEG_BLANK;
      end
      return SEG_TABLE[d];
   endfunction

endpackage

// File: rtl/reloj_hhmmss_if.sv
// rtl/reloj_hhmmss_if.sv - pulse/button inputs and time/display outputs of the clock
// Purpose: bundles everything except F1/rst_n.
// Ports:   tick_1hz, tick_scan, btn_min, btn_hr (into the clock);
//          time_bcd[23:0], an[3:0], seg[6:0], dp (out of the clock).
//          slave = clock side, master = driver/observer side.
interface reloj_hhmmss_if;
   logic        tick_1hz;
   logic        tick_scan;
   logic        btn_min;
   logic        btn_hr;
   logic [23:0] time_bcd;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport slave (
      input  tick_1hz, tick_scan, btn_min, btn_hr,
      output time_bcd, an, seg, dp
   );

   modport master (
      output tick_1hz, tick_scan, btn_min, btn_hr,
      input  time_bcd, an, seg, dp
   );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, level debouncer and rising-edge set pulse
// Purpose: accepts a new button level only after DEB_CYCLES consecutive equal
//          synchronized samples; emits one F1-cycle pulse when 1 is accepted.
// Ports:   F1 clock, rst_n async active-low reset, i_btn raw button,
//          o_pulse registered single-cycle set pulse.
module btn_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic F1,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int              CNT_W    = 20;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;

   // r_cnt counts consecutive samples that disagree with the accepted level;
   // any sample equal to the accepted level restarts the count.
   always_ff @(posedge F1 or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_pulse <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/reloj_hhmmss.sv
// rtl/reloj_hhmmss.sv - 24-hour BCD clock with button setting and 4-digit scanned display
// Purpose: counts hh:mm:ss on tick_1hz, applies debounced minute/hour set pulses,
//          scans mm/hh onto a multiplexed active-low 7-segment display.
// Ports:   F1 clock, rst_n async active-low reset,
//          bus (slave): tick_1hz, tick_scan, btn_min, btn_hr in;
//                       time_bcd, an, seg, dp out (all registered).
module reloj_hhmmss
   import reloj_hhmmss_pkg::*;
#(
   parameter int DEB_CYCLES = 50000
) (
   input logic           F1,
   input logic           rst_n,
   reloj_hhmmss_if.slave bus
);

   logic w_set_min;
   logic w_set_hr;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_min (
      .F1      (F1),
      .rst_n   (rst_n),
      .i_btn   (bus.btn_min),
      .o_pulse (w_set_min)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hr (
      .F1      (F1),
      .rst_n   (rst_n),
      .i_btn   (bus.btn_hr),
      .o_pulse (w_set_hr)
   );

   // ---------------- time counter ----------------
   logic [3:0] r_hr_t, r_hr_u, r_min_t, r_min_u, r_sec_t, r_sec_u;

   logic       w_sec_wrap, w_min_wrap, w_hr_wrap;
   logic [3:0] w_sec_u_inc, w_sec_t_inc, w_min_u_inc, w_min_t_inc, w_hr_u_inc, w_hr_t_inc;

   always_comb begin
      w_sec_wrap  = (r_sec_t == BCD_TENS_MAX) && (r_sec_u == BCD_UNITS_MAX);
      w_min_wrap  = (r_min_t == BCD_TENS_MAX) && (r_min_u == BCD_UNITS_MAX);
      w_hr_wrap   = (r_hr_t == HR_TENS_MAX) && (r_hr_u == HR_UNITS_MAX);

      w_sec_u_inc = (r_sec_u == BCD_UNITS_MAX) ? 4'd0 : r_sec_u + 4'd1;
      w_sec_t_inc = (r_sec_u != BCD_UNITS_MAX) ? r_sec_t :
                    (w_sec_wrap ? 4'd0 : r_sec_t + 4'd1);
      w_min_u_inc = (r_min_u == BCD_UNITS_MAX) ? 4'd0 : r_min_u + 4'd1;
      w_min_t_inc = (r_min_u != BCD_UNITS_MAX) ? r_min_t :
                    (w_min_wrap ? 4'd0 : r_min_t + 4'd1);
      // 23 -> 00 overrides the normal units/tens rollover
      w_hr_u_inc  = w_hr_wrap ? 4'd0 :
                    ((r_hr_u == BCD_UNITS_MAX) ? 4'd0 : r_hr_u + 4'd1);
      w_hr_t_inc  = w_hr_wrap ? 4'd0 :
                    ((r_hr_u == BCD_UNITS_MAX) ? r_hr_t + 4'd1 : r_hr_t);
   end

   // Set pulses take priority: a tick in the same cycle is dropped.
   always_ff @(posedge F1 or negedge rst_n) begin
      if (!rst_n) begin
         r_hr_t  <= 4'd0;
         r_hr_u  <= 4'd0;
         r_min_t <= 4'd0;
         r_min_u <= 4'd0;
         r_sec_t <= 4'd0;
         r_sec_u <= 4'd0;
      end else if (w_set_min || w_set_hr) begin
         if (w_set_min) begin
            r_min_u <= w_min_u_inc;
            r_min_t <= w_min_t_inc;
            r_sec_u <= 4'd0;
            r_sec_t <= 4'd0;
         end
         if (w_set_hr) begin
            r_hr_u <= w_hr_u_inc;
            r_hr_t <= w_hr_t_inc;
         end
      end else if (bus.tick_1hz) begin
         r_sec_u <= w_sec_u_inc;
         r_sec_t <= w_sec_t_inc;
         if (w_sec_wrap) begin
            r_min_u <= w_min_u_inc;
            r_min_t <= w_min_t_inc;
            if (w_min_wrap) begin
               r_hr_u <= w_hr_u_inc;
               r_hr_t <= w_hr_t_inc;
            end
         end
      end
   end

   assign bus.time_bcd = {r_hr_t, r_hr_u, r_min_t, r_min_u, r_sec_t, r_sec_u};

   // ---------------- display scan ----------------
   scan_e      r_scan;
   scan_e      w_scan_next;
   logic [3:0] w_an;
   logic [3:0] w_digit;
   logic       w_dp;
   logic [3:0] r_an;
   logic [6:0] r_seg;
   logic       r_dp;

   always_ff @(posedge F1 or negedge rst_n) begin
      if (!rst_n) begin
         r_scan <= SCAN_MIN_U;
      end else begin
         r_scan <= w_scan_next;
      end
   end

   // Outputs are decoded from the next index so the digit change lands on the
   // same edge as the index change.
   always_comb begin
      w_scan_next = r_scan;
      w_an        = 4'b1110;
      w_digit     = r_min_u;
      if (bus.tick_scan) begin
         case (r_scan)
            SCAN_MIN_U: w_scan_next = SCAN_MIN_T;
            SCAN_MIN_T: w_scan_next = SCAN_HR_U;
            SCAN_HR_U:  w_scan_next = SCAN_HR_T;
            default:    w_scan_next = SCAN_MIN_U;
         endcase
      end
      case (w_scan_next)
         SCAN_MIN_U: begin w_an = 4'b1110; w_digit = r_min_u; end
         SCAN_MIN_T: begin w_an = 4'b1101; w_digit = r_min_t; end
         SCAN_HR_U:  begin w_an = 4'b1011; w_digit = r_hr_u;  end
         default:    begin w_an = 4'b0111; w_digit = r_hr_t;  end
      endcase
      // colon lit on the hours-units digit during even seconds
      w_dp = ~((w_scan_next == SCAN_HR_U) && !r_sec_u[0]);
   end

   always_ff @(posedge F1 or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= 4'b1110;
         r_seg <= SEG_TABLE[0];
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an;
         r_seg <= seg_encode(w_digit);
         r_dp  <= w_dp;
      end
   end

   assign bus.an  = r_an;
   assign bus.seg = r_seg;
   assign bus.dp  = r_dp;

endmodule

// File: tb/tb_reloj_hhmmss.sv
// tb/tb_reloj_hhmmss.sv - self-checking scoreboard bench for reloj_hhmmss
module tb_reloj_hhmmss;

   logic F1;
   logic rst_n;

   reloj_hhmmss_if bus ();

   reloj_hhmmss #(.DEB_CYCLES(4)) dut (
      .F1    (F1),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial F1 = 1'b0;
   always #5 F1 = ~F1;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // model state
   int m_h, m_m, m_s, m_idx;

   logic [6:0] tb_seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_bcd();
      logic [23:0] v;
      v = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
      return {8'h0, v};
   endfunction

   function automatic logic [31:0] model_disp();
      logic [3:0] an;
      int         d;
      logic       dp;
      case (m_idx)
         0:       begin an = 4'b1110; d = m_m % 10; end
         1:       begin an = 4'b1101; d = m_m / 10; end
         2:       begin an = 4'b1011; d = m_h % 10; end
         default: begin an = 4'b0111; d = m_h / 10; end
      endcase
      dp = (m_idx == 2 && ((m_s % 10) % 2) == 0) ? 1'b0 : 1'b1;
      return {20'h0, an, tb_seg[d], dp};
   endfunction

   function automatic void model_tick();
      m_s++;
      if (m_s == 60) begin
         m_s = 0;
         m_m++;
         if (m_m == 60) begin
            m_m = 0;
            m_h = (m_h + 1) % 24;
         end
      end
   endfunction

   task automatic push_exp(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] got);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check_eq(e.tag, got, e.val);
   endtask

   task automatic cycle();
      @(posedge F1);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_time"}, {8'h0, bus.time_bcd}, 32'h0);
      check_eq({tag, "_an"},   {28'h0, bus.an}, 32'hE);
      check_eq({tag, "_seg"},  {25'h0, bus.seg}, 32'h40);
      check_eq({tag, "_dp"},   {31'h0, bus.dp}, 32'h1);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #2;
      check_reset_outputs(tag);
      m_h = 0; m_m = 0; m_s = 0; m_idx = 0;
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic do_tick(input string tag);
      bus.tick_1hz = 1'b1;
      model_tick();
      push_exp(tag, model_bcd());
      cycle();
      bus.tick_1hz = 1'b0;
      pop_check({8'h0, bus.time_bcd});
   endtask

   // press, hold well past the debounce window, release and let it settle
   task automatic do_press(input bit set_min, input bit set_hr, input string tag);
      bus.btn_min = set_min;
      bus.btn_hr  = set_hr;
      repeat (10) cycle();
      bus.btn_min = 1'b0;
      bus.btn_hr  = 1'b0;
      repeat (10) cycle();
      if (set_min) begin m_m = (m_m + 1) % 60; m_s = 0; end
      if (set_hr) m_h = (m_h + 1) % 24;
      push_exp(tag, model_bcd());
      pop_check({8'h0, bus.time_bcd});
   endtask

   task automatic do_scan(input string tag);
      bus.tick_scan = 1'b1;
      m_idx = (m_idx + 1) % 4;
      push_exp(tag, model_disp());
      cycle();
      bus.tick_scan = 1'b0;
      pop_check({20'h0, bus.an, bus.seg, bus.dp});
   endtask

   task automatic set_to(input int h, input int m);
      repeat (h) do_press(1'b0, 1'b1, "set_hr");
      repeat (m) do_press(1'b1, 1'b0, "set_min");
   endtask

   initial begin
      rst_n         = 1'b1;
      bus.tick_1hz  = 1'b0;
      bus.tick_scan = 1'b0;
      bus.btn_min   = 1'b0;
      bus.btn_hr    = 1'b0;
      cycle();

      // seconds count and carry into minutes
      do_reset("rst0");
      repeat (59) do_tick("tick_sec");
      check_eq("t59", {8'h0, bus.time_bcd}, 32'h000059);
      do_tick("tick_carry_min");
      check_eq("t100", {8'h0, bus.time_bcd}, 32'h000100);

      // bouncing press accepted once, short pulse rejected
      do_reset("rst1");
      bus.btn_min = 1; cycle();
      bus.btn_min = 0; repeat (2) cycle();
      bus.btn_min = 1; repeat (3) cycle();
      bus.btn_min = 0; cycle();
      bus.btn_min = 1; repeat (2) cycle();
      bus.btn_min = 0; cycle();
      bus.btn_min = 1; repeat (10) cycle();
      bus.btn_min = 0; repeat (10) cycle();
      m_m = 1;
      push_exp("bounce_one", model_bcd());
      pop_check({8'h0, bus.time_bcd});
      bus.btn_min = 1; repeat (3) cycle();
      bus.btn_min = 0; repeat (12) cycle();
      push_exp("short_none", model_bcd());
      pop_check({8'h0, bus.time_bcd});

      // full-day rollover
      do_reset("rst2");
      set_to(23, 59);
      check_eq("set_2359", {8'h0, bus.time_bcd}, 32'h235900);
      repeat (59) do_tick("tick_day");
      check_eq("t235959", {8'h0, bus.time_bcd}, 32'h235959);
      do_tick("tick_wrap");
      check_eq("t000000", {8'h0, bus.time_bcd}, 32'h000000);

      // set pulse and tick in the same cycle: 2 sync stages + 4 samples, then pulse
      do_reset("rst3");
      repeat (30) do_tick("tick_30");
      bus.btn_min = 1'b1;
      repeat (6) cycle();
      bus.tick_1hz = 1'b1;
      m_m = 1; m_s = 0;
      push_exp("set_vs_tick", model_bcd());
      cycle();
      bus.tick_1hz = 1'b0;
      pop_check({8'h0, bus.time_bcd});
      repeat (10) cycle();
      bus.btn_min = 1'b0;
      repeat (10) cycle();
      push_exp("hold_no_repeat", model_bcd());
      pop_check({8'h0, bus.time_bcd});

      // display scan at 12:34:00
      do_reset("rst4");
      set_to(12, 34);
      while (m_idx != 3) do_scan("scan_align");
      do_scan("scan_mu");
      do_scan("scan_mt");
      do_scan("scan_hu");
      do_scan("scan_ht");
      // both set buttons together after some seconds
      repeat (5) do_tick("tick_5");
      do_press(1'b1, 1'b1, "set_both");
      check_eq("t133500", {8'h0, bus.time_bcd}, 32'h133500);

      // reset mid-debounce at 05:17:42
      do_reset("rst5");
      set_to(5, 17);
      repeat (42) do_tick("tick_42");
      check_eq("t051742", {8'h0, bus.time_bcd}, 32'h051742);
      bus.btn_min = 1'b1;
      repeat (3) cycle();
      rst_n = 1'b0;
      #2;
      check_reset_outputs("rst_async");
      m_h = 0; m_m = 0; m_s = 0; m_idx = 0;
      bus.btn_min = 1'b0;
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (20) cycle();
      push_exp("no_spurious", model_bcd());
      pop_check({8'h0, bus.time_bcd});

      // button held across reset release yields exactly one pulse
      bus.btn_min = 1'b1;
      repeat (3) cycle();
      rst_n = 1'b0;
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (10) cycle();
      bus.btn_min = 1'b0;
      repeat (10) cycle();
      m_m = 1;
      push_exp("held_through_rst", model_bcd());
      pop_check({8'h0, bus.time_bcd});

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
